// File: rtl/execute_pipe_if.sv
// Bundles the E-stage inputs, forwarding outputs and M pipeline register of execute_pipe.
// master = upstream/downstream pipeline side, slave = the execute stage itself.
interface execute_pipe_if;
  logic [1:0]  E_stat;
  logic [3:0]  E_in_code;
  logic [3:0]  E_fn_code;
  logic [63:0] E_val_c;
  logic [63:0] E_val_a;
  logic [63:0] E_val_b;
  logic [3:0]  E_dst_e;
  logic [3:0]  E_dst_m;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic        M_bubble;

  logic [63:0] e_val_e;
  logic        e_cnd;
  logic [3:0]  e_dst_e;
  logic [2:0]  cc;

  logic [1:0]  M_stat;
  logic [3:0]  M_in_code;
  logic        M_cnd;
  logic [63:0] M_val_e;
  logic [63:0] M_val_a;
  logic [3:0]  M_dst_e;
  logic [3:0]  M_dst_m;

  modport master (
    output E_stat, E_in_code, E_fn_code, E_val_c, E_val_a, E_val_b,
           E_dst_e, E_dst_m, m_stat, W_stat, M_bubble,
    input  e_val_e, e_cnd, e_dst_e, cc,
           M_stat, M_in_code, M_cnd, M_val_e, M_val_a, M_dst_e, M_dst_m
  );

  modport slave (
    input  E_stat, E_in_code, E_fn_code, E_val_c, E_val_a, E_val_b,
           E_dst_e, E_dst_m, m_stat, W_stat, M_bubble,
    output e_val_e, e_cnd, e_dst_e, cc,
           M_stat, M_in_code, M_cnd, M_val_e, M_val_a, M_dst_e, M_dst_m
  );
endinterface

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: ALU, condition codes, jXX/cmovXX evaluation and the M pipeline register.
// Optional EXECUTE_OP_CNT_EN adds op_count, a count of CC-updating OPq instructions.
module execute_pipe (
  input  logic                clock,
  input  logic                reset_n,
  execute_pipe_if.slave       bus
`ifdef EXECUTE_OP_CNT_EN
  ,
  output logic [31:0]         op_count
`endif
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  logic [3:0]        alu_fn;
  logic [WORD_W-1:0] alu_res;
  logic              new_zf;
  logic              new_sf;
  logic              new_of;
  logic              set_cc;
  logic              cnd;
  logic              zf, sf, of;

  assign {zf, sf, of} = bus.cc;

  // Operand selection and ALU
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (bus.E_in_code)
      I_RRMOVQ, I_OPQ:              alu_a = bus.E_val_a;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_val_c;
      I_CALL, I_PUSHQ:              alu_a = WORD_W'(-64'sd8);
      I_RET, I_POPQ:                alu_a = WORD_W'(64'd8);
      default: ;
    endcase
    case (bus.E_in_code)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_val_b;
      default: ;
    endcase

    alu_fn = (bus.E_in_code == I_OPQ) ? bus.E_fn_code : ALU_ADD;

    alu_res = '0;
    new_of  = 1'b0;
    case (alu_fn)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        new_of  = (alu_a[WORD_W-1] == alu_b[WORD_W-1]) && (alu_res[WORD_W-1] != alu_a[WORD_W-1]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        new_of  = (alu_a[WORD_W-1] != alu_b[WORD_W-1]) && (alu_res[WORD_W-1] != alu_b[WORD_W-1]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: ;
    endcase
    new_zf = (alu_res == '0);
    new_sf = alu_res[WORD_W-1];
  end

  assign set_cc = (bus.E_in_code == I_OPQ) && (bus.E_stat == STAT_AOK) &&
                  (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);

  // Branch/cmov condition uses the stored flags, not this cycle's ALU flags
  always_comb begin
    cnd = 1'b0;
    case (bus.E_fn_code)
      4'h0: cnd = 1'b1;
      4'h1: cnd = (sf ^ of) | zf;
      4'h2: cnd = sf ^ of;
      4'h3: cnd = zf;
      4'h4: cnd = ~zf;
      4'h5: cnd = ~(sf ^ of);
      4'h6: cnd = ~(sf ^ of) & ~zf;
      default: ;
    endcase
  end

  assign bus.e_val_e = alu_res;
  assign bus.e_cnd   = cnd;
  assign bus.e_dst_e = ((bus.E_in_code == I_RRMOVQ) && !cnd) ? REG_NONE : bus.E_dst_e;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.cc <= 3'b100;
    end else if (set_cc) begin
      bus.cc <= {new_zf, new_sf, new_of};
    end
  end

  // M pipeline register; bubble overrides the E inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || bus.M_bubble) begin
      bus.M_stat    <= STAT_AOK;
      bus.M_in_code <= I_NOP;
      bus.M_cnd     <= 1'b0;
      bus.M_val_e   <= '0;
      bus.M_val_a   <= '0;
      bus.M_dst_e   <= REG_NONE;
      bus.M_dst_m   <= REG_NONE;
    end else begin
      bus.M_stat    <= bus.E_stat;
      bus.M_in_code <= bus.E_in_code;
      bus.M_cnd     <= cnd;
      bus.M_val_e   <= alu_res;
      bus.M_val_a   <= bus.E_val_a;
      bus.M_dst_e   <= bus.e_dst_e;
      bus.M_dst_m   <= bus.E_dst_m;
    end
  end

`ifdef EXECUTE_OP_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (set_cc) begin
      op_count <= op_count + CNT_W'(1);
    end
  end
`else
  localparam int unsigned CNT_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe: reset, ALU/flags, conditions, CC suppression, bubble.
module tb_execute_pipe;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_fail;

  execute_pipe_if bus ();

`ifdef EXECUTE_OP_CNT_EN
  logic [31:0] op_count;
  execute_pipe dut (.clock(clock), .reset_n(reset_n), .bus(bus), .op_count(op_count));
`else
  execute_pipe dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm);
    @(negedge clock);
    bus.E_in_code = icode;
    bus.E_fn_code = fn;
    bus.E_val_a   = va;
    bus.E_val_b   = vb;
    bus.E_val_c   = vc;
    bus.E_dst_e   = de;
    bus.E_dst_m   = dm;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset_n      = 1'b1;
    bus.E_stat   = 2'b00;
    bus.E_in_code = 4'h1;
    bus.E_fn_code = 4'h0;
    bus.E_val_a  = '0;
    bus.E_val_b  = '0;
    bus.E_val_c  = '0;
    bus.E_dst_e  = 4'hF;
    bus.E_dst_m  = 4'hF;
    bus.m_stat   = 2'b00;
    bus.W_stat   = 2'b00;
    bus.M_bubble = 1'b0;

    // Asynchronous reset asserted mid-cycle
    #12 reset_n = 1'b0;
    #1;
    chk("rst_cc",      64'(bus.cc), 64'h4);
    chk("rst_in_code", 64'(bus.M_in_code), 64'h1);
    chk("rst_dst_e",   64'(bus.M_dst_e), 64'hF);
    chk("rst_dst_m",   64'(bus.M_dst_m), 64'hF);
    chk("rst_val_e",   bus.M_val_e, 64'h0);
    chk("rst_stat",    64'(bus.M_stat), 64'h0);
`ifdef EXECUTE_OP_CNT_EN
    chk("rst_opcnt",   64'(op_count), 64'h0);
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // OPq sub: 3 - 5
    drive(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF);
    chk("sub_e_val_e", bus.e_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("sub_M_val_e", bus.M_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_cc",      64'(bus.cc), 64'h2);
    chk("sub_M_dst_e", 64'(bus.M_dst_e), 64'h2);
    chk("sub_M_code",  64'(bus.M_in_code), 64'h6);
`ifdef EXECUTE_OP_CNT_EN
    chk("sub_opcnt",   64'(op_count), 64'h1);
`endif

    // jl after the sub sees SF^OF = 1
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    chk("jl_e_cnd",    64'(bus.e_cnd), 64'h1);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    chk("je_e_cnd",    64'(bus.e_cnd), 64'h0);
    tick();
    chk("je_M_cnd",    64'(bus.M_cnd), 64'h0);

    // Add overflow
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF);
    tick();
    chk("addov_val_e", bus.M_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("addov_cc",    64'(bus.cc), 64'h3);

    // 1 + 2 leaves all flags clear
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h1, 4'hF);
    tick();
    chk("add_cc",      64'(bus.cc), 64'h0);
    chk("add_val_e",   bus.M_val_e, 64'd3);

    // cmovge taken, cmovle not taken
    drive(4'h2, 4'h5, 64'd9, 64'd0, 64'd0, 4'h3, 4'hF);
    chk("cmovge_dst",  64'(bus.e_dst_e), 64'h3);
    drive(4'h2, 4'h1, 64'd9, 64'd0, 64'd0, 4'h3, 4'hF);
    chk("cmovle_cnd",  64'(bus.e_cnd), 64'h0);
    chk("cmovle_dst",  64'(bus.e_dst_e), 64'hF);
    tick();
    chk("cmovle_Mdst", 64'(bus.M_dst_e), 64'hF);
    chk("cmovle_Mval", bus.M_val_e, 64'd9);
    chk("cmovle_Mva",  bus.M_val_a, 64'd9);

    // OPq xor with memory stage faulting: CC held, M loads
    drive(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 4'h4, 4'hF);
    bus.m_stat = 2'b10;
    tick();
    chk("supp_cc",     64'(bus.cc), 64'h0);
    chk("supp_val_e",  bus.M_val_e, 64'h0);
    chk("supp_stat",   64'(bus.M_stat), 64'h0);
    chk("supp_code",   64'(bus.M_in_code), 64'h6);
`ifdef EXECUTE_OP_CNT_EN
    chk("supp_opcnt",  64'(op_count), 64'h3);
`endif
    bus.m_stat = 2'b00;

    // Writeback-stage status also suppresses
    drive(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 4'h4, 4'hF);
    bus.W_stat = 2'b01;
    tick();
    chk("suppw_cc",    64'(bus.cc), 64'h0);
    bus.W_stat = 2'b00;

    // pushq with bubble on the same edge
    drive(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4, 4'hF);
    bus.M_bubble = 1'b1;
    #1;
    chk("push_e_val_e", bus.e_val_e, 64'hF8);
    tick();
    chk("bub_code",    64'(bus.M_in_code), 64'h1);
    chk("bub_val_e",   bus.M_val_e, 64'h0);
    chk("bub_val_a",   bus.M_val_a, 64'h0);
    chk("bub_dst_e",   64'(bus.M_dst_e), 64'hF);
    chk("bub_cc",      64'(bus.cc), 64'h0);
`ifdef EXECUTE_OP_CNT_EN
    chk("bub_opcnt",   64'(op_count), 64'h3);
`endif
    bus.M_bubble = 1'b0;

    // popq adds +8
    drive(4'hB, 4'h0, 64'hF8, 64'hF8, 64'd0, 4'h4, 4'h5);
    tick();
    chk("pop_val_e",   bus.M_val_e, 64'h100);
    chk("pop_dst_m",   64'(bus.M_dst_m), 64'h5);

    // Undefined OPq function gives 0, so ZF sets
    drive(4'h6, 4'h4, 64'd1, 64'd2, 64'd0, 4'h1, 4'hF);
    tick();
    chk("fn4_val_e",   bus.M_val_e, 64'h0);
    chk("fn4_cc",      64'(bus.cc), 64'h4);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF);
    chk("je_taken",    64'(bus.e_cnd), 64'h1);
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF);
    chk("fn7_cnd",     64'(bus.e_cnd), 64'h0);
    drive(4'h5, 4'h0, 64'd0, 64'h1000, 64'h18, 4'hF, 4'h6);
    chk("mrmov_val_e", bus.e_val_e, 64'h1018);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Execute stage of the five-stage Y86-64 pipeline. It sits between the decode/E pipeline register and the memory stage. It computes the ALU result and holds the condition-code register (ZF, SF, OF). It evaluates jXX/cmovXX conditions and registers everything the memory stage consumes into the M pipeline register. It also exports the combinational e_* values needed for forwarding.

## Interface
Parameters:
- none (status encoding fixed: 2'b00 AOK, 2'b01 HLT, 2'b10 ADR, 2'b11 INS; register id 4'hF = none)

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- E_stat  input  2  status of instruction in E
- E_in_code  input  4  icode (0 halt,1 nop,2 rrmovq/cmovXX,3 irmovq,4 rmmovq,5 mrmovq,6 OPq,7 jXX,8 call,9 ret,10 pushq,11 popq)
- E_fn_code  input  4  ifun
- E_val_c, E_val_a, E_val_b  input  64 each  constant word, operand A, operand B
- E_dst_e, E_dst_m  input  4 each  destination register ids
- m_stat, W_stat  input  2 each  status in memory and writeback stages (CC suppression)
- M_bubble  input  1  load bubble into M register this edge
- e_val_e  output  64  combinational ALU result
- e_cnd  output  1  combinational condition result
- e_dst_e  output  4  combinational effective dst_e
- cc  output  3  {ZF,SF,OF} register
- M_stat, M_in_code, M_cnd, M_val_e, M_val_a, M_dst_e, M_dst_m  output  2/4/1/64/64/4/4  M pipeline register

## Operation
- aluA: E_val_a for icode 2,6; E_val_c for 3,4,5; -8 for 8,10; +8 for 9,11; 0 otherwise.
- aluB: E_val_b for 4,5,6,8,9,10,11; 0 for 2,3 and all others.
- ALU function: icode 6 uses E_fn_code (0 add B+A, 1 sub B-A, 2 and, 3 xor; 4-15 produce 0). All other icodes add. 64-bit modulo arithmetic.
- Flags from the result: ZF = result==0; SF = result[63].
- OF for add: A[63]==B[63] and result[63]!=A[63]. OF for sub: A[63]!=B[63] and result[63]!=B[63]. OF for and/xor: 0.
- set_cc = (E_in_code==6) & (E_stat==AOK) & (m_stat==AOK) & (W_stat==AOK). CC loads new flags only when set_cc is high.
- e_cnd is computed from the current cc register, not from the flags being written:
  - fn 0: 1
  - fn 1 le: (SF^OF)|ZF
  - fn 2 l: SF^OF
  - fn 3 e: ZF
  - fn 4 ne: ~ZF
  - fn 5 ge: ~(SF^OF)
  - fn 6 g: ~(SF^OF)&~ZF
  - fn 7-15: 0
- e_cnd is meaningful for icodes 2 and 7 only; for other icodes it is passed through but not used.
- e_dst_e = 4'hF when E_in_code==2 and e_cnd==0; otherwise E_dst_e.
- M register captures E_stat, E_in_code, e_cnd, e_val_e, E_val_a, e_dst_e and E_dst_m. No state machine; one pipeline slot.
- Bubble value: stat AOK, in_code 1, cnd 0, val_e 0, val_a 0, dst_e 4'hF, dst_m 4'hF.

## Timing
- e_val_e, e_cnd and e_dst_e are combinational from E_* and cc in the same cycle.
- M_* outputs: one-cycle latency at the rising clock edge. cc updates at the same edge.
- An instruction that follows an OPq sees the updated CC when it reaches E, one cycle later.
- M_bubble=1 loads the bubble value at the edge; it overrides the E inputs. CC is unaffected by M_bubble.
- Reset (reset_n=0), asynchronous, takes effect immediately even mid-cycle:
  - M_* = bubble value
  - cc = 3'b100 (ZF=1, SF=0, OF=0)
  - the configurable counter = 0
- Outputs hold their reset values while reset_n is low. Normal operation starts at the first edge after reset deasserts.
- If an OPq arrives while m_stat or W_stat is not AOK, CC holds its value and the M register still loads normally.

## Configuration
- EXECUTE_OP_CNT_EN defined: adds output op_count [31:0]. It increments at every edge where set_cc=1, wraps from 32'hFFFFFFFF to 0, and resets to 0.
- EXECUTE_OP_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: drive reset_n=0 mid-cycle, check the following immediately:
  - cc=3'b100
  - M_in_code=1
  - M_dst_e=M_dst_m=4'hF
  - M_val_e=0
- OPq sub: fn=1, val_a=5, val_b=3, one edge. Expect:
  - M_val_e=64'hFFFFFFFFFFFFFFFE
  - cc={0,1,0}
  - next cycle jXX fn=2 gives e_cnd=1
- Add overflow: fn=0, A=B=64'h7FFFFFFFFFFFFFFF. Expect result 64'hFFFFFFFFFFFFFFFE and cc={0,1,1}.
- cmovle not taken: cc={0,0,0}, icode 2, fn 1, E_dst_e=3. Expect e_dst_e=4'hF and M_dst_e=4'hF after the edge.
- CC suppression: OPq xor with A=B=7 while m_stat=2'b10. Expect cc unchanged, M_val_e=0 and M_stat equal to E_stat.
- Stack and bubble:
  - pushq with val_b=64'h100 gives e_val_e=64'hF8.
  - M_bubble=1 on the same edge gives M_in_code=1, M_val_e=0.
  - With EXECUTE_OP_CNT_EN, op_count is unchanged.
